oflow_pe_feed_buffer: RTL and testbench
=======================================

// Module: oflow_pe_feed_buffer
// PURPOSE
//  Buffer-side end of the buffer<->PE interface. Holds previous-frame feature vectors in a ping-pong memory.
//  Streams them to one PE two entries per row (data_to_pe_0/1 + row_sel_to_pe), paced by the PE's
//  control_for_read_new_line, and signals done_read_to_pe after the last row.
//  Concurrently stores the PE's current-frame features (data_out_pe) into the other bank; banks swap per frame.
// PARAMETERS
//  DATA_W   `DATA_TO_PE_WIDTH      width of one entry sent to the PE
//  FEAT_W   `FEATURE_OF_PREV_LEN   width of one entry written back by the PE (zero-extended/truncated to DATA_W)
//  DEPTH    64                     entries per bank, power of 2, even
//  ADDR_W   $clog2(DEPTH)          entry address width
//  ROW_W    `ROW_LEN               row index width, >= ADDR_W-1
// PORTS
//  clk                        in   1       clock
//  reset_N                    in   1       asynchronous, active-low reset
//  start_read                 in   1       pulse: begin streaming previous frame
//  num_of_objects_prev        in   ADDR_W+1  entries valid in read bank (N)
//  control_for_read_new_line  in   1       PE pulse: current row consumed, send next
//  data_to_pe_0               out  DATA_W  entry 2r of read bank
//  data_to_pe_1               out  DATA_W  entry 2r+1 of read bank (0 if 2r+1 >= N)
//  row_sel_to_pe              out  ROW_W   current row r
//  valid_to_pe                out  1       data_to_pe_0/1, row_sel_to_pe are valid
//  done_read_to_pe            out  1       1-cycle pulse: all rows delivered
//  busy                       out  1       state != IDLE
//  wr_en                      in   1       write data_out_pe into write bank
//  wr_addr                    in   ADDR_W  write address
//  data_out_pe                in   FEAT_W  current-frame feature vector from PE
//  swap_banks                 in   1       pulse: frame boundary, exchange read/write banks
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bank_sel=0 (bank0=read, bank1=write); row=0; swap_pending=0.
//  Memory: 2 banks x DEPTH/2 rows x 2 entries, synchronous read (1-cycle latency), one write port.
//  FSM IDLE -> FETCH -> HOLD -> (FETCH | LAST) -> IDLE.
//   IDLE:  start_read: latch Nc=min(N,DEPTH), rows=ceil(Nc/2). Nc==0 -> LAST. Else row=0, issue read -> FETCH.
//   FETCH: read data returns; regs load data_to_pe_0/1, row_sel_to_pe=row; valid_to_pe=1 next cycle -> HOLD.
//   HOLD:  outputs held stable, valid_to_pe=1, until control_for_read_new_line.
//          On request: valid_to_pe=0 next cycle. If row==rows-1 -> LAST; else row++, issue read -> FETCH.
//          Latency: request at cycle t -> new row valid at t+2.
//   LAST:  done_read_to_pe=1 for exactly one cycle; valid_to_pe=0; row=0 -> IDLE.
//  control_for_read_new_line outside HOLD ignored. start_read outside IDLE ignored.
//  Odd Nc: last row's data_to_pe_1 forced to 0. Nc=1: single row.
//  Write: wr_en writes {zero-ext data_out_pe} to entry wr_addr of write bank in any state. Never touches read bank.
//  swap_banks: in IDLE toggles bank_sel next cycle. Otherwise sets swap_pending; applied on LAST->IDLE.
//  Simultaneous in IDLE: swap_banks+start_read -> swap applied first, stream reads the new read bank.
//  Simultaneous wr_en+swap_banks: write lands in the pre-swap write bank.
//  Read of an entry never written since reset returns 0 (banks cleared at reset).
//  Reset mid-stream: immediate return to reset state; any pending done/swap is lost.
// STRUCTURE
//  Package oflow_pe_feed_pkg: typedef enum {IDLE,FETCH,HOLD,LAST} feed_state_t; entry_t (DATA_W); row_t (ROW_W).
//  One sub-module: oflow_pe_feed_bank_mem (2-bank dual-entry RAM, sync read, write port, bank_sel input).
//  Top: FSM, row counter, swap_pending, output registers.
// TESTING
//  1. Write entries 0..4 = 0x10..0x14 to bank1, swap, start N=5 -> rows 0,1,2 =
//     (0x10,0x11),(0x12,0x13),(0x14,0); done pulse 1 cycle after 3rd request.
//  2. start N=0 -> done_read_to_pe pulses within 2 cycles; valid_to_pe never 1.
//  3. Hold request off 10 cycles in HOLD -> outputs stable all 10 cycles; request -> next row valid exactly 2 cycles later.
//  4. swap_banks during row 1 of 3 -> bank_sel unchanged until done; toggles on LAST->IDLE.
//  5. wr_en each cycle while streaming N=DEPTH -> all DEPTH/2 rows match pre-swap bank; writes visible after next swap.
//  6. reset_N low in HOLD -> valid_to_pe=0, busy=0, bank_sel=0 same cycle; start N=2 after release -> normal 1-row stream.

Source files
------------

// File: rtl/oflow_pe_feed_pkg.sv
// Shared types and default widths for the buffer-to-PE feed path.
package oflow_pe_feed_pkg;

  localparam int DATA_TO_PE_WIDTH    = 32;
  localparam int FEATURE_OF_PREV_LEN = 24;
  localparam int ROW_LEN             = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    LAST  = 2'd3
  } feed_state_t;

  typedef logic [DATA_TO_PE_WIDTH-1:0] entry_t;
  typedef logic [ROW_LEN-1:0]          row_t;

endpackage

// File: rtl/oflow_pe_feed_bank_mem.sv
// Two-bank RAM organised as rows of two entries: one row read port (registered), one entry write port.
module oflow_pe_feed_bank_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              bank_sel_i,
  input  logic              swap_now_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-2:0] rd_row_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o
);

  // Read bank follows a same-cycle swap; writes always target the pre-swap write bank.
  logic [ADDR_W-1:0] rd_a;
  logic [ADDR_W-1:0] wr_a;
  logic [DATA_W-1:0] rd_data [2];

  assign rd_a = {bank_sel_i ^ swap_now_i, rd_row_i};
  assign wr_a = {~bank_sel_i, wr_addr_i[ADDR_W-1:1]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DATA_W-1:0] rd_q;
    logic              rd_vld_q;
    logic              wr_hit;

    assign wr_hit = wr_en_i && (wr_addr_i[0] == 1'(gi));

    always_ff @(posedge clk) begin
      if (wr_hit) mem_q[wr_a] <= wr_data_i;
      if (rd_en_i) rd_q <= mem_q[rd_a];
    end

    // Per-entry written flags give "cleared at reset" without resetting the RAM array itself.
    always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
        vld_q    <= '0;
        rd_vld_q <= 1'b0;
      end else begin
        if (wr_hit) vld_q[wr_a] <= 1'b1;
        if (rd_en_i) rd_vld_q <= vld_q[rd_a];
      end
    end

    assign rd_data[gi] = rd_q & {DATA_W{rd_vld_q}};
  end

  assign rd_data0_o = rd_data[0];
  assign rd_data1_o = rd_data[1];

endmodule

// File: rtl/oflow_pe_feed_buffer.sv
// Ping-pong feature buffer: streams previous-frame entries to a PE two per row, stores current-frame results.
module oflow_pe_feed_buffer
  import oflow_pe_feed_pkg::*;
#(
  parameter int DATA_W = DATA_TO_PE_WIDTH,
  parameter int FEAT_W = FEATURE_OF_PREV_LEN,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ROW_W  = ROW_LEN
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start_read,
  input  logic [ADDR_W:0]   num_of_objects_prev,
  input  logic              control_for_read_new_line,
  output logic [DATA_W-1:0] data_to_pe_0,
  output logic [DATA_W-1:0] data_to_pe_1,
  output logic [ROW_W-1:0]  row_sel_to_pe,
  output logic              valid_to_pe,
  output logic              done_read_to_pe,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [FEAT_W-1:0] data_out_pe,
  input  logic              swap_banks
);

  feed_state_t       state_q, state_d;
  logic [ADDR_W-2:0] row_q, row_d;
  logic [ADDR_W-2:0] last_row_q, last_row_d;
  logic              odd_q, odd_d;
  logic              bank_sel_q, bank_sel_d;
  logic              swap_pend_q, swap_pend_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [ROW_W-1:0]  row_sel_q, row_sel_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              rd_en;
  logic [ADDR_W-2:0] rd_row;
  logic              swap_now;
  logic [ADDR_W:0]   nc;
  logic [ADDR_W:0]   nc_m1;
  logic [DATA_W-1:0] rd_data0, rd_data1;

  oflow_pe_feed_bank_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk       (clk),
    .reset_ni  (reset_N),
    .bank_sel_i(bank_sel_q),
    .swap_now_i(swap_now),
    .rd_en_i   (rd_en),
    .rd_row_i  (rd_row),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (DATA_W'(data_out_pe)),
    .rd_data0_o(rd_data0),
    .rd_data1_o(rd_data1)
  );

  assign nc    = (num_of_objects_prev > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_of_objects_prev;
  assign nc_m1 = nc - 1'b1;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    last_row_d  = last_row_q;
    odd_d       = odd_q;
    bank_sel_d  = bank_sel_q;
    swap_pend_d = swap_pend_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    row_sel_d   = row_sel_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    rd_en       = 1'b0;
    rd_row      = row_q;
    swap_now    = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_banks) bank_sel_d = ~bank_sel_q;
        if (start_read) begin
          last_row_d = (ADDR_W-1)'(nc_m1 >> 1);
          odd_d      = nc[0];
          row_d      = '0;
          if (nc == '0) begin
            done_d  = 1'b1;
            state_d = LAST;
          end else begin
            rd_en    = 1'b1;
            rd_row   = '0;
            swap_now = swap_banks;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        data0_d   = rd_data0;
        data1_d   = (odd_q && row_q == last_row_q) ? '0 : rd_data1;
        row_sel_d = ROW_W'(row_q);
        valid_d   = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (control_for_read_new_line) begin
          valid_d = 1'b0;
          if (row_q == last_row_q) begin
            done_d  = 1'b1;
            state_d = LAST;
          end else begin
            row_d   = row_q + 1'b1;
            rd_en   = 1'b1;
            rd_row  = row_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      LAST: begin
        // A swap requested mid-stream (or during this cycle) lands here.
        if (swap_pend_q || swap_banks) bank_sel_d = ~bank_sel_q;
        swap_pend_d = 1'b0;
        row_d       = '0;
        valid_d     = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (swap_banks && (state_q == FETCH || state_q == HOLD)) swap_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= IDLE;
      row_q       <= '0;
      last_row_q  <= '0;
      odd_q       <= 1'b0;
      bank_sel_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      row_sel_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      last_row_q  <= last_row_d;
      odd_q       <= odd_d;
      bank_sel_q  <= bank_sel_d;
      swap_pend_q <= swap_pend_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      row_sel_q   <= row_sel_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign data_to_pe_0    = data0_q;
  assign data_to_pe_1    = data1_q;
  assign row_sel_to_pe   = row_sel_q;
  assign valid_to_pe     = valid_q;
  assign done_read_to_pe = done_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_oflow_pe_feed_buffer.sv
// Directed and randomized bench for oflow_pe_feed_buffer against a two-bank array model.
module tb_oflow_pe_feed_buffer;

  localparam int DATA_W = 32;
  localparam int FEAT_W = 24;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int ROW_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_N;
  logic              start_read;
  logic [ADDR_W:0]   num_of_objects_prev;
  logic              control_for_read_new_line;
  logic [DATA_W-1:0] data_to_pe_0;
  logic [DATA_W-1:0] data_to_pe_1;
  logic [ROW_W-1:0]  row_sel_to_pe;
  logic              valid_to_pe;
  logic              done_read_to_pe;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [FEAT_W-1:0] data_out_pe;
  logic              swap_banks;

  oflow_pe_feed_buffer #(
    .DATA_W(DATA_W),
    .FEAT_W(FEAT_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .ROW_W (ROW_W)
  ) dut (
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_read               (start_read),
    .num_of_objects_prev      (num_of_objects_prev),
    .control_for_read_new_line(control_for_read_new_line),
    .data_to_pe_0             (data_to_pe_0),
    .data_to_pe_1             (data_to_pe_1),
    .row_sel_to_pe            (row_sel_to_pe),
    .valid_to_pe              (valid_to_pe),
    .done_read_to_pe          (done_read_to_pe),
    .busy                     (busy),
    .wr_en                    (wr_en),
    .wr_addr                  (wr_addr),
    .data_out_pe              (data_out_pe),
    .swap_banks               (swap_banks)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the two banks as flat entry arrays plus which one is being read.
  logic [DATA_W-1:0] mbank [2][DEPTH];
  int                bsel;
  bit                pend;
  bit                storm;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ctl();
    return 128'({valid_to_pe, done_read_to_pe, busy});
  endfunction

  function automatic logic [127:0] row_obs();
    return 128'({valid_to_pe, done_read_to_pe, data_to_pe_0, data_to_pe_1, row_sel_to_pe});
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) mbank[b][a] = '0;
    bsel = 0;
    pend = 0;
  endtask

  task automatic tick();
    if (storm) begin
      wr_en       = 1'b1;
      wr_addr     = ADDR_W'($urandom);
      data_out_pe = FEAT_W'($urandom);
      mbank[1-bsel][wr_addr] = DATA_W'(data_out_pe);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr(int a, logic [FEAT_W-1:0] d, bit with_swap);
    wr_en       = 1'b1;
    wr_addr     = ADDR_W'(a);
    data_out_pe = d;
    swap_banks  = with_swap;
    mbank[1-bsel][a] = DATA_W'(d);
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    swap_banks = 1'b0;
    if (with_swap) bsel = 1 - bsel;
  endtask

  task automatic swap_idle();
    swap_banks = 1'b1;
    tick();
    swap_banks = 1'b0;
    bsel = 1 - bsel;
  endtask

  task automatic fill_write_bank();
    for (int a = 0; a < DEPTH; a++) wr(a, FEAT_W'($urandom), 1'b0);
  endtask

  // Stream n entries; hold<0 picks a random 0..3 cycle hold per row.
  task automatic stream(int n, int hold, bit swap_start, int swap_row);
    int nc, rows, rb, h;
    logic [DATA_W-1:0] e0, e1;
    logic [ROW_W-1:0]  rs;
    logic [127:0]      exp_v;
    nc   = (n > DEPTH) ? DEPTH : n;
    rows = (nc + 1) / 2;
    num_of_objects_prev = (ADDR_W+1)'(n);
    start_read = 1'b1;
    swap_banks = swap_start;
    if (swap_start) bsel = 1 - bsel;
    tick();
    start_read = 1'b0;
    swap_banks = 1'b0;
    if (nc == 0) begin
      check("empty_done", ctl(), 128'(3'b011));
      tick();
      check("empty_end", ctl(), 128'(3'b000));
      return;
    end
    check("fetch0", ctl(), 128'(3'b001));
    tick();
    rb = bsel;
    for (int r = 0; r < rows; r++) begin
      e0    = mbank[rb][2*r];
      e1    = (2*r + 1 < nc) ? mbank[rb][2*r+1] : '0;
      rs    = r[ROW_W-1:0];
      exp_v = 128'({1'b1, 1'b0, e0, e1, rs});
      check("row", row_obs(), exp_v);
      if (r == swap_row) begin
        swap_banks = 1'b1;
        tick();
        swap_banks = 1'b0;
        pend = 1;
        check("swap_hold", row_obs(), exp_v);
      end
      h = (hold < 0) ? $urandom_range(0, 3) : hold;
      for (int k = 0; k < h; k++) begin
        tick();
        check("hold", row_obs(), exp_v);
      end
      control_for_read_new_line = 1'b1;
      tick();
      control_for_read_new_line = 1'b0;
      if (r == rows - 1) begin
        check("last_done", ctl(), 128'(3'b011));
      end else begin
        check("gap", ctl(), 128'(3'b001));
        tick();
      end
    end
    tick();
    check("idle", ctl(), 128'(3'b000));
    if (pend) begin
      bsel = 1 - bsel;
      pend = 0;
    end
  endtask

  initial begin
    reset_N = 1'b0;
    start_read = 1'b0;
    num_of_objects_prev = '0;
    control_for_read_new_line = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    data_out_pe = '0;
    swap_banks = 1'b0;
    storm = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    reset_N = 1'b1;
    tick();
    check("reset_outs", 128'({row_obs(), busy}), 128'(0));

    // Five entries into the write bank, swap, three rows with odd tail.
    for (int a = 0; a < 5; a++) wr(a, FEAT_W'(32'h10 + a), 1'b0);
    swap_idle();
    stream(5, 0, 1'b0, -1);

    stream(0, 0, 1'b0, -1);
    stream(6, 10, 1'b0, -1);

    // Mid-stream swap is deferred until the stream ends.
    fill_write_bank();
    swap_idle();
    fill_write_bank();
    stream(6, -1, 1'b0, 1);
    stream(6, -1, 1'b0, -1);

    // Writes every cycle during a full-depth stream, then read them back.
    storm = 1;
    stream(DEPTH, -1, 1'b0, -1);
    storm = 0;
    swap_idle();
    stream(DEPTH, -1, 1'b0, -1);

    // Write coinciding with swap, then swap coinciding with start.
    wr(3, FEAT_W'($urandom), 1'b1);
    stream(4, -1, 1'b0, -1);
    fill_write_bank();
    stream(5, -1, 1'b1, -1);
    stream(1, -1, 1'b0, -1);
    stream(100, -1, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      fill_write_bank();
      stream($urandom_range(0, 2*DEPTH-1), -1, 1'($urandom), -1);
    end

    // Asynchronous reset while holding a row.
    num_of_objects_prev = 7'd4;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    tick();
    check("pre_rst_valid", 128'(valid_to_pe), 128'(1));
    reset_N = 1'b0;
    #1;
    check("rst_async", 128'({row_obs(), busy}), 128'(0));
    @(posedge clk);
    #1;
    reset_N = 1'b1;
    clear_model();
    tick();
    stream(2, -1, 1'b0, -1);
    wr(0, 24'hABCDEF, 1'b0);
    wr(1, 24'h123456, 1'b0);
    stream(2, -1, 1'b0, -1);
    swap_idle();
    stream(2, -1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
